bip_fetch_unit: RTL
===================

# bip_fetch_unit

Instruction fetch stage of the BIP accumulator processor. It sequences the program counter and issues one read per instruction to program memory. It registers the returned 16-bit word and presents it downstream as a 5-bit opcode and an 11-bit operand over a valid/ready handshake. The operand output feeds the sign-extension stage directly; the opcode feeds the control decoder.

## Interface
Parameters:
- PC_NBITS, 11, program counter and memory address width
- INSTR_NBITS, 16, instruction word width
- OPCODE_NBITS, 5, opcode field width (instruction bits [15:11])
- OPERAND_NBITS, 11, operand field width (instruction bits [10:0])
- CNT_NBITS, 32, cycle counter width

Ports:
- i_clock  in  1  single clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle pulse; starts execution from IDLE or HALTED
- o_mem_req  out  1  program memory read request
- o_mem_addr  out  PC_NBITS  read address (current PC)
- i_mem_valid  in  1  read data valid
- i_mem_data  in  INSTR_NBITS  read data
- o_valid  out  1  decoded instruction available
- i_ready  in  1  downstream accepts instruction
- o_opcode  out  OPCODE_NBITS  instruction register bits [15:11]
- o_operand  out  OPERAND_NBITS  instruction register bits [10:0]; raw, not sign-extended
- o_pc  out  PC_NBITS  address of the instruction currently presented
- o_halted  out  1  HLT instruction has been accepted downstream
- o_cycle_count  out  CNT_NBITS  active-cycle count; present only with the macro

## Operation
- The FSM has four states: IDLE, FETCH, ISSUE, HALTED.
- IDLE (reset state):
  - All outputs are 0.
  - i_start → FETCH with PC=0.
- FETCH:
  - o_mem_req=1 and o_mem_addr=PC.
  - Request and address are held stable until i_mem_valid is sampled high.
  - On i_mem_valid: IR←i_mem_data, o_pc←PC, PC←PC+1, then → ISSUE.
- ISSUE:
  - o_valid=1; o_opcode, o_operand and o_pc are stable; o_mem_req=0.
  - Transfer happens when o_valid && i_ready.
  - After the transfer: if opcode == OP_HLT (5'b00000) → HALTED, otherwise → FETCH.
  - The HLT instruction itself is handed downstream before halting.
- HALTED:
  - o_halted=1, no requests are issued, and IR/o_pc hold their values.
  - i_start → FETCH with PC=0 and o_halted cleared.
- i_mem_valid outside FETCH is ignored.
- i_start outside IDLE and HALTED is ignored.
- PC increments modulo 2^PC_NBITS; 0x7FF wraps to 0x000 silently.

## Timing
- Reset values: state=IDLE, PC=0, IR=0, o_pc=0, o_mem_req=0, o_valid=0, o_halted=0, o_cycle_count=0.
- Asynchronous reset takes effect immediately in any state. A response arriving during or in the same cycle as reset is dropped.
- The first request is asserted the cycle after i_start is sampled.
- o_valid rises the cycle after i_mem_valid is sampled.
- With zero-wait memory (valid in the same cycle as req) and i_ready held high: one instruction per 2 cycles.
- With i_ready low, o_valid stays high and the fields are unchanged; no new request is issued.
- Outputs are registered; there is no combinational path from i_ready or i_mem_valid to any output.

## Configuration
- Macro: FETCH_CYCLE_COUNTER_EN.
- Defined:
  - o_cycle_count exists and increments each cycle the FSM is in FETCH or ISSUE.
  - It saturates at all-ones.
  - It is cleared by i_start from IDLE or HALTED and holds its value while HALTED.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package bip_pkg:
  - opcode localparams (OP_HLT=5'b00000 plus the rest of the ISA)
  - FSM state encoding (2-bit: IDLE, FETCH, ISSUE, HALTED)
  - field position constants for opcode and operand slicing
- Sub-module bip_cycle_counter (saturating, clear/enable inputs). It is instantiated only under FETCH_CYCLE_COUNTER_EN.

## Test plan
- Reset idle: release reset, no i_start for 10 cycles → o_mem_req=0, o_valid=0, o_halted=0, all outputs 0.
- Zero-wait run:
  - Stimulus: memory[0..2]=0x0805, 0x17FF, 0x0000; i_ready=1; pulse i_start.
  - Required: three transfers with opcode/operand/o_pc = (1,0x005,0), (2,0x7FF,1), (0,0x000,2).
  - Then o_halted=1 and o_cycle_count=6.
- Memory wait: i_mem_valid delayed 3 cycles → o_mem_req and o_mem_addr stable for 4 cycles; o_valid rises exactly 1 cycle after valid.
- Backpressure: i_ready low 5 cycles during ISSUE → o_valid high and fields unchanged; o_mem_req=0; the next fetch starts the cycle after i_ready rises.
- Wrap: 2048 non-HLT words (0x0801) → after address 0x7FF, o_mem_addr returns to 0x000.
- Reset mid-FETCH:
  - Stimulus: assert i_reset low in the same cycle as i_mem_valid with data 0x1234.
  - Required: state IDLE, IR=0, o_valid=0.
  - A later i_start fetches from address 0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator processor: ISA opcodes, fetch FSM
// state encoding and instruction field positions.
package bip_pkg;

    // BIP instruction set
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    // Instruction word layout: opcode in [15:11], operand in [10:0]
    localparam int unsigned OPCODE_MSB  = 15;
    localparam int unsigned OPCODE_LSB  = 11;
    localparam int unsigned OPERAND_MSB = 10;
    localparam int unsigned OPERAND_LSB = 0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StIssue  = 2'd2,
        StHalted = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/bip_cycle_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module bip_cycle_counter #(
    parameter int unsigned NBITS = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [NBITS-1:0] o_count
);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_clear) begin
            o_count <= '0;
        end else if (i_enable && (o_count != '1)) begin
            o_count <= o_count + NBITS'(1);
        end
    end

endmodule

// File: rtl/bip_fetch_unit.sv
// BIP instruction fetch stage: PC sequencing, program memory reads and a
// valid/ready instruction output. Define FETCH_CYCLE_COUNTER_EN for o_cycle_count.
module bip_fetch_unit
    import bip_pkg::*;
#(
    parameter int unsigned PC_NBITS      = 11,
    parameter int unsigned INSTR_NBITS   = 16,
    parameter int unsigned OPCODE_NBITS  = 5,
    parameter int unsigned OPERAND_NBITS = 11,
    parameter int unsigned CNT_NBITS     = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_start,
    output logic                     o_mem_req,
    output logic [PC_NBITS-1:0]      o_mem_addr,
    input  logic                     i_mem_valid,
    input  logic [INSTR_NBITS-1:0]   i_mem_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [OPCODE_NBITS-1:0]  o_opcode,
    output logic [OPERAND_NBITS-1:0] o_operand,
    output logic [PC_NBITS-1:0]      o_pc,
    output logic                     o_halted
`ifdef FETCH_CYCLE_COUNTER_EN
    ,
    output logic [CNT_NBITS-1:0]     o_cycle_count
`endif
);

    fetch_state_e           state_q;
    logic [PC_NBITS-1:0]    pc_q;
    logic [INSTR_NBITS-1:0] ir_q;

    assign o_opcode   = ir_q[OPCODE_LSB +: OPCODE_NBITS];
    assign o_operand  = ir_q[OPERAND_LSB +: OPERAND_NBITS];
    // pc_q only advances on a read response, so it is the live address while in FETCH
    assign o_mem_addr = pc_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            o_pc      <= '0;
            o_mem_req <= 1'b0;
            o_valid   <= 1'b0;
            o_halted  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StHalted: begin
                    if (i_start) begin
                        state_q   <= StFetch;
                        pc_q      <= '0;
                        o_mem_req <= 1'b1;
                        o_halted  <= 1'b0;
                    end
                end
                StFetch: begin
                    if (i_mem_valid) begin
                        state_q   <= StIssue;
                        ir_q      <= i_mem_data;
                        o_pc      <= pc_q;
                        pc_q      <= pc_q + PC_NBITS'(1);
                        o_mem_req <= 1'b0;
                        o_valid   <= 1'b1;
                    end
                end
                StIssue: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        // HLT is handed downstream first, then the unit parks
                        if (o_opcode == OP_HLT) begin
                            state_q  <= StHalted;
                            o_halted <= 1'b1;
                        end else begin
                            state_q   <= StFetch;
                            o_mem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_COUNTER_EN
    logic cnt_clear;
    logic cnt_enable;

    assign cnt_clear  = i_start && ((state_q == StIdle) || (state_q == StHalted));
    assign cnt_enable = (state_q == StFetch) || (state_q == StIssue);

    bip_cycle_counter #(
        .NBITS(CNT_NBITS)
    ) u_cycle_counter (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (cnt_clear),
        .i_enable (cnt_enable),
        .o_count  (o_cycle_count)
    );
`endif

endmodule
